npc_seq_ctrl: RTL
=================

// Module: npc_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the NPC RV32 datapath. Owns the architectural PC and
//  steps each instruction through FETCH -> EXEC -> (MEM) -> WB, with req/ready
//  handshakes to the instruction-fetch and load/store units. Gates the register
//  file write enable, detects ebreak (halt) and bus timeouts (error).
// PARAMETERS
//  RESET_PC  32'h8000_0000  PC loaded on reset
//  TIMEOUT   256            max wait cycles in FETCH/MEM before ERR; 0 = no timeout
//  CNT_W     9              width of wait counter; must hold TIMEOUT
// PORTS
//  clk        in   1   core clock; all state changes on rising edge
//  rst        in   1   synchronous, active-high reset
//  ifu_req    out  1   fetch request, asserted throughout FETCH
//  ifu_ready  in   1   fetch done; ifu_inst valid this cycle
//  ifu_inst   in   32  fetched instruction word
//  inst       out  32  latched instruction driven to decoder/datapath
//  pc         out  32  current PC
//  next_pc    in   32  PC computed by the pc-update logic for the current inst
//  lsu_req    out  1   data-memory request, asserted throughout MEM
//  lsu_we     out  1   1 = store, 0 = load; valid while lsu_req=1
//  lsu_ready  in   1   data access done (load data valid this cycle)
//  reg_wen    out  1   register file write enable, one-cycle pulse in WB
//  instret    out  32  retired instruction count, wraps at 2^32
//  halted     out  1   sticky: ebreak executed
//  err        out  1   sticky: handshake timeout
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=FETCH, pc=RESET_PC, inst=0, instret=0,
//    halted=0, err=0, wait counter=0. Outputs are registered-state decodes, so
//    cycle after reset: ifu_req=1, lsu_req=0, reg_wen=0. rst mid-instruction
//    aborts it: no write, no PC update, no instret increment.
//  - States: FETCH, EXEC, MEM, WB, HALT, ERR (3-bit encoding, free choice).
//  - FETCH: ifu_req=1. On ifu_ready: inst<=ifu_inst, -> EXEC. Else wait cnt++.
//  - EXEC: one cycle for datapath to settle. inst==32'h0010_0073 (ebreak) -> HALT;
//    opcode 7'b0000011 (load) or 7'b0100011 (store) -> MEM; else -> WB.
//  - MEM: lsu_req=1, lsu_we=(opcode==7'b0100011). On lsu_ready -> WB; else cnt++.
//  - WB: reg_wen=1 unless opcode is store (0100011) or branch (1100011);
//    pc<=next_pc; instret<=instret+1; -> FETCH.
//  - HALT: all reqs and reg_wen 0, halted=1, pc frozen; instret counts ebreak
//    (+1 on EXEC->HALT). Leaves only via rst.
//  - ERR: entered from FETCH/MEM when TIMEOUT!=0 and cnt==TIMEOUT-1 with ready
//    still 0. err=1, reqs 0, pc/instret frozen. Leaves only via rst.
//  - Wait counter clears on every state entry; ready in the same cycle as the
//    timeout threshold wins (transition proceeds, no ERR).
//  - Requests are never dropped before ready. ifu_ready outside FETCH and
//    lsu_ready outside MEM are ignored.
//  - Latency: non-memory inst = 3 cycles min (ready in first FETCH cycle);
//    load/store = 4 cycles min; each stall cycle adds 1.
//  - inst and pc are stable from EXEC through WB of the same instruction.
// TESTING
//  1 rst 1 cycle -> pc=0x8000_0000, ifu_req=1, reg_wen=0, instret=0, halted=err=0.
//  2 addi x1,x0,5 (0x0050_0093), ifu_ready immediate, next_pc=0x8000_0004 ->
//    reg_wen pulses once in cycle 3, then pc=0x8000_0004, instret=1.
//  3 lw 0x0000_A103, lsu_ready after 3 low cycles -> lsu_req high 4 cycles,
//    lsu_we=0, single reg_wen pulse after, total 7 cycles.
//  4 sw 0x0020_A023 -> lsu_we=1 during MEM, reg_wen never 1, instret+1.
//  5 ebreak 0x0010_0073 -> halted=1 sticky, ifu_req=0, pc unchanged, instret+1;
//    ifu_ready pulses ignored until rst.
//  6 TIMEOUT=8, ifu_ready held 0 -> err=1 after 8 FETCH cycles; ready at cycle 8
//    instead -> no err, EXEC follows; rst during MEM -> FETCH, no reg_wen.

Source files
------------

// File: rtl/npc_seq_ctrl.sv
// Multi-cycle instruction sequencer for the NPC RV32 datapath: owns the PC, steps
// each instruction FETCH -> EXEC -> (MEM) -> WB and flags ebreak halts and bus timeouts.
module npc_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 256,
    parameter int unsigned CNT_W    = 9
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req,
    input  logic        ifu_ready,
    input  logic [31:0] ifu_inst,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic [31:0] next_pc,
    output logic        lsu_req,
    output logic        lsu_we,
    input  logic        lsu_ready,
    output logic        reg_wen,
    output logic [31:0] instret,
    output logic        halted,
    output logic        err
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC  = 3'd1,
        S_MEM   = 3'd2,
        S_WB    = 3'd3,
        S_HALT  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [31:0] EBREAK    = 32'h0010_0073;

    // TIMEOUT == 0 disables the watchdog; CNT_LAST is then never consulted.
    localparam bit              TO_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic [31:0]       inst_q;
    logic [31:0]       pc_q;
    logic [31:0]       instret_q;

    logic [6:0]        opcode;
    logic              is_load;
    logic              is_store;
    logic              is_branch;
    logic              is_ebreak;
    logic              timeout_hit;
    logic              retire;

    assign opcode      = inst_q[6:0];
    assign is_load     = (opcode == OP_LOAD);
    assign is_store    = (opcode == OP_STORE);
    assign is_branch   = (opcode == OP_BRANCH);
    assign is_ebreak   = (inst_q == EBREAK);
    assign timeout_hit = TO_EN && (wait_cnt == CNT_LAST);

    // ebreak retires on entry to HALT, every other instruction on leaving WB.
    assign retire = (state == S_WB) || ((state == S_EXEC) && is_ebreak);

    always_comb begin
        state_nxt = state;
        ifu_req   = 1'b0;
        lsu_req   = 1'b0;
        lsu_we    = 1'b0;
        reg_wen   = 1'b0;
        halted    = 1'b0;
        err       = 1'b0;
        case (state)
            S_FETCH: begin
                ifu_req = 1'b1;
                if (ifu_ready)
                    state_nxt = S_EXEC;
                else if (timeout_hit)
                    state_nxt = S_ERR;
            end
            S_EXEC: begin
                if (is_ebreak)
                    state_nxt = S_HALT;
                else if (is_load || is_store)
                    state_nxt = S_MEM;
                else
                    state_nxt = S_WB;
            end
            S_MEM: begin
                lsu_req = 1'b1;
                lsu_we  = is_store;
                // ready on the threshold cycle takes priority over the timeout
                if (lsu_ready)
                    state_nxt = S_WB;
                else if (timeout_hit)
                    state_nxt = S_ERR;
            end
            S_WB: begin
                reg_wen   = !(is_store || is_branch);
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            inst_q    <= '0;
            pc_q      <= RESET_PC;
            instret_q <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                wait_cnt <= '0;
            else if ((state == S_FETCH) || (state == S_MEM))
                wait_cnt <= wait_cnt + CNT_W'(1);
            if ((state == S_FETCH) && ifu_ready)
                inst_q <= ifu_inst;
            if (state == S_WB)
                pc_q <= next_pc;
            if (retire)
                instret_q <= instret_q + 32'd1;
        end
    end

    assign inst    = inst_q;
    assign pc      = pc_q;
    assign instret = instret_q;

endmodule
